// File: rtl/hcsr04_distance.sv
// HC-SR04 echo conditioning: 4-sample moving average, cycles->cm divide, clamp, BCD.
// Fixed 35-cycle latency from accepted strobe to o_valid; strobes while busy are dropped.
module hcsr04_distance #(
  parameter int T_CLK          = 10,
  parameter int CNT_PER_CM     = 58000 / T_CLK,
  parameter int TIMEOUT_COUNTS = 3_799_998,
  parameter int RANGE_MAX_CM   = 400
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [21:0] i_echo_time,
  input  logic        i_echo_valid,
  output logic        o_busy,
  output logic [9:0]  o_dist_cm,
  output logic [11:0] o_dist_bcd,
  output logic        o_out_of_range,
  output logic        o_valid
);

  localparam logic [21:0] TIMEOUT_L = 22'(TIMEOUT_COUNTS);
  localparam logic [22:0] DIVISOR   = 23'(CNT_PER_CM);
  localparam logic [21:0] MAX_L     = 22'(RANGE_MAX_CM);
  localparam logic [4:0]  DIV_LAST  = 5'd21;
  localparam logic [4:0]  BCD_LAST  = 5'd9;

  typedef enum logic [2:0] {IDLE, ACCUM, DIV, CLAMP, BCD, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [21:0] sample_q;
  logic [21:0] win_q [4];
  logic [21:0] win_d [4];
  logic        filled_q;
  logic        oor_q;
  logic [22:0] rem_q;
  logic [21:0] quo_q;
  logic [9:0]  value_q;
  logic [9:0]  shift_q;
  logic [11:0] bcd_q;
  logic        busy_q;
  logic [9:0]  dist_q;
  logic [11:0] dist_bcd_q;
  logic        oor_out_q;
  logic        valid_q;

  logic        accept, do_accum, do_div, do_clamp, do_bcd, bcd_last, in_done;

  // ---------------- state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_echo_valid) state_d = ACCUM;
      ACCUM:   state_d = DIV;
      DIV:     if (cnt_q == DIV_LAST) state_d = CLAMP;
      CLAMP:   state_d = BCD;
      BCD:     if (cnt_q == BCD_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- control decode ----------------
  always_comb begin
    accept   = (state_q == IDLE) && i_echo_valid;
    do_accum = (state_q == ACCUM);
    do_div   = (state_q == DIV);
    do_clamp = (state_q == CLAMP);
    do_bcd   = (state_q == BCD);
    bcd_last = do_bcd && (cnt_q == BCD_LAST);
    in_done  = (state_q == DONE);
    cnt_d    = (state_d != state_q) ? 5'd0 : cnt_q + 5'd1;
  end

  // ---------------- datapath combinational ----------------
  logic        sample_oor;
  logic [23:0] win_sum;
  logic [21:0] avg;
  logic [22:0] trial;
  logic        trial_ge;
  logic        clamp;
  logic [9:0]  clamp_val;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    sample_oor = (sample_q >= TIMEOUT_L);
    for (int i = 0; i < 4; i++) win_d[i] = win_q[i];
    if (do_accum && !sample_oor) begin
      if (!filled_q) begin
        for (int i = 0; i < 4; i++) win_d[i] = sample_q;
      end else begin
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = win_q[3];
        win_d[3] = sample_q;
      end
    end
    win_sum = {2'b00, win_d[0]} + {2'b00, win_d[1]} + {2'b00, win_d[2]} + {2'b00, win_d[3]};
    // A timeout before any valid sample has nothing to average.
    avg = (sample_oor && !filled_q) ? 22'd0 : win_sum[23:2];

    trial    = {rem_q[21:0], quo_q[21]};
    trial_ge = (trial >= DIVISOR);

    clamp     = (quo_q > MAX_L) || oor_q;
    clamp_val = clamp ? MAX_L[9:0] : quo_q[9:0];

    bcd_adj  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_next = {bcd_adj[10:0], shift_q[9]};
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_q   <= '0;
      for (int i = 0; i < 4; i++) win_q[i] <= '0;
      filled_q   <= 1'b0;
      oor_q      <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      value_q    <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      dist_q     <= '0;
      dist_bcd_q <= '0;
      oor_out_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        sample_q <= i_echo_time;
        busy_q   <= 1'b1;
      end
      if (do_accum) begin
        for (int i = 0; i < 4; i++) win_q[i] <= win_d[i];
        if (!sample_oor) filled_q <= 1'b1;
        oor_q <= sample_oor;
        quo_q <= avg;
        rem_q <= '0;
      end
      if (do_div) begin
        rem_q <= trial_ge ? (trial - DIVISOR) : trial;
        quo_q <= {quo_q[20:0], trial_ge};
      end
      if (do_clamp) begin
        value_q <= clamp_val;
        shift_q <= clamp_val;
        oor_q   <= clamp;
        bcd_q   <= '0;
      end
      if (do_bcd) begin
        bcd_q   <= bcd_next;
        shift_q <= {shift_q[8:0], 1'b0};
      end
      // Outputs land on the edge into DONE so o_valid is high during DONE.
      if (bcd_last) begin
        dist_q     <= value_q;
        dist_bcd_q <= bcd_next;
        oor_out_q  <= oor_q;
        valid_q    <= 1'b1;
      end
      if (in_done) busy_q <= 1'b0;
    end
  end

  assign o_busy         = busy_q;
  assign o_dist_cm      = dist_q;
  assign o_dist_bcd     = dist_bcd_q;
  assign o_out_of_range = oor_out_q;
  assign o_valid        = valid_q;

endmodule

// File: tb/tb_hcsr04_distance.sv
// Scoreboard bench for hcsr04_distance: directed test-plan cases plus random samples.
module tb_hcsr04_distance;

  localparam int TIMEOUT = 3_799_998;
  localparam int CPC     = 5800;
  localparam int MAXCM   = 400;
  localparam int LAT     = 35;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] echo_time = '0;
  logic        echo_valid = 1'b0;
  logic        busy, oor, valid;
  logic [9:0]  dist_cm;
  logic [11:0] dist_bcd;

  hcsr04_distance dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_echo_time    (echo_time),
    .i_echo_valid   (echo_valid),
    .o_busy         (busy),
    .o_dist_cm      (dist_cm),
    .o_dist_bcd     (dist_bcd),
    .o_out_of_range (oor),
    .o_valid        (valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cm;
    int bcd;
    int oor;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int unsigned mwin[$];
  int          last_n = -1000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
    end
  endtask

  function automatic exp_t model(input int t, input int n);
    exp_t e;
    int   sum, avg, q, d;
    bit   is_oor;
    is_oor = (t >= TIMEOUT);
    if (!is_oor) begin
      if (mwin.size() == 0) begin
        repeat (4) mwin.push_back(t);
      end else begin
        void'(mwin.pop_front());
        mwin.push_back(t);
      end
    end
    sum = 0;
    foreach (mwin[i]) sum += mwin[i];
    avg = (mwin.size() == 0) ? 0 : sum / 4;
    q = avg / CPC;
    if (is_oor || q > MAXCM) begin
      d = MAXCM;
      e.oor = 1;
    end else begin
      d = q;
      e.oor = 0;
    end
    e.cm  = d;
    e.bcd = ((d / 100) << 8) | (((d / 10) % 10) << 4) | (d % 10);
    e.due = n + LAT;
    return e;
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int t);
    echo_time  = 22'(t);
    echo_valid = 1'b1;
    if (cyc >= last_n + LAT + 1) begin
      last_n = cyc;
      sbq.push_back(model(t, cyc));
    end
    @(posedge clk);
    #1;
    echo_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dist_cm", int'(dist_cm), 0);
    chk("rst_dist_bcd", int'(dist_bcd), 0);
    chk("rst_oor", int'(oor), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    sbq.delete();
    mwin.delete();
    last_n = -1000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    wait_to(last_n + LAT + 1);
  endtask

  // Monitor: busy window and o_valid results against the scoreboard front.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit exp_busy = (sbq.size() > 0) && (cyc >= sbq[0].due - (LAT - 1)) && (cyc <= sbq[0].due);
      chk("busy", int'(busy), int'(exp_busy));
      if (valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          automatic exp_t e = sbq.pop_front();
          chk("valid_cycle", cyc, e.due);
          chk("dist_cm", int'(dist_cm), e.cm);
          chk("dist_bcd", int'(dist_bcd), e.bcd);
          chk("out_of_range", int'(oor), e.oor);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        chk("missing_valid", 0, 1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int n, t;
    @(posedge clk);
    #1;
    do_reset();

    send(58_000);     settle();
    send(116_000);    settle();
    send(TIMEOUT);    settle();
    send(58_000);     settle();

    do_reset(); send(2_320_000); settle();
    do_reset(); send(2_325_800); settle();
    do_reset(); send(5_799);     settle();
    do_reset(); send(TIMEOUT);   settle();

    // Strobes at N+10 and N+35 must be dropped.
    n = cyc;
    send(290_000);
    wait_to(n + 10); send(580_000);
    wait_to(n + 35); send(1_740_000);
    settle();
    send(290_000);    settle();

    // Reset during the divide aborts without o_valid and empties the window.
    send(1_160_000);  settle();
    n = cyc;
    send(2_000_000);
    wait_to(n + 20);
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    send(58_000);     settle();

    for (int i = 0; i < 40; i++) begin
      wait_to(last_n + LAT + 1 + $urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) t = TIMEOUT + $urandom_range(0, 394_305);
      else t = $urandom_range(0, TIMEOUT - 1);
      send(t);
      if ($urandom_range(0, 3) == 0) begin
        wait_to(cyc + $urandom_range(0, 30));
        send($urandom_range(0, TIMEOUT - 1));
      end
    end

    settle();
    repeat (50) @(posedge clk);
    #1;
    chk("drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
